// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one saturating adder across N_CH sample channels.
// Each channel integrates ACC_LEN samples; finished window sums leave on a tagged valid/ready port.

module adder #(
  parameter int IN_WIDTH = 16,
  parameter bit SIGNED   = 1'b1
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  output logic [IN_WIDTH-1:0] sum,
  output logic                sat
);

  logic [IN_WIDTH:0] raw;
  logic              ovf;
  logic              carry;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[IN_WIDTH];
    // Signed overflow: operands agree in sign, result does not.
    ovf   = (a[IN_WIDTH-1] == b[IN_WIDTH-1]) && (raw[IN_WIDTH-1] != a[IN_WIDTH-1]);
    sat   = SIGNED ? ovf : carry;
    sum   = raw[IN_WIDTH-1:0];
    if (SIGNED && ovf) begin
      sum = a[IN_WIDTH-1] ? {1'b1, {(IN_WIDTH-1){1'b0}}} : {1'b0, {(IN_WIDTH-1){1'b1}}};
    end else if (!SIGNED && carry) begin
      sum = '1;
    end
  end

endmodule

module adder_sched #(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int ACC_LEN   = 8,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*IN_WIDTH-1:0]  in_data,
  output logic [N_CH-1:0]           in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic                      out_sat
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ACC_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

  logic [ACC_WIDTH-1:0] acc [N_CH];
  logic [CNT_W-1:0]     cnt [N_CH];
  logic [N_CH-1:0]      sat;
  logic [CH_W-1:0]      ptr;

  logic [N_CH-1:0]      elig;
  logic [N_CH-1:0]      grant;
  logic [CH_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic                 stall;
  logic                 closing;
  logic [IN_WIDTH-1:0]  smp;
  logic [ACC_WIDTH-1:0] smp_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_sat;

  assign stall = out_valid & ~out_ready;

  // Only a window-closing sample is held off while the output is stalled.
  for (genvar k = 0; k < N_CH; k++) begin : g_elig
    assign elig[k] = in_valid[k] & ~(stall & (cnt[k] == LAST));
  end

  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] idx_c;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CH_W'(idx);
      if (!gnt_any && elig[idx_c]) begin
        gnt_any        = 1'b1;
        gnt_idx        = idx_c;
        grant[idx_c]   = 1'b1;
      end
    end
  end

  assign in_ready = rst_n ? grant : '0;
  assign closing  = gnt_any && (cnt[gnt_idx] == LAST);

  always_comb begin
    smp = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == gnt_idx) smp = in_data[k*IN_WIDTH +: IN_WIDTH];
    end
    smp_ext = {{(ACC_WIDTH-IN_WIDTH){SIGNED & smp[IN_WIDTH-1]}}, smp};
  end

  adder #(
    .IN_WIDTH (ACC_WIDTH),
    .SIGNED   (SIGNED)
  ) u_adder (
    .a   (acc[gnt_idx]),
    .b   (smp_ext),
    .sum (sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      sat <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
    end else if (gnt_any) begin
      ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      if (closing) begin
        acc[gnt_idx] <= '0;
        cnt[gnt_idx] <= '0;
        sat[gnt_idx] <= 1'b0;
      end else begin
        acc[gnt_idx] <= sum;
        cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
        sat[gnt_idx] <= sat[gnt_idx] | add_sat;
      end
    end
  end

  // A close can only occur when the output slot is empty or draining, so loading never overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (closing) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      out_ch    <= gnt_idx;
      out_sat   <= sat[gnt_idx] | add_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: three configurations share one stimulus stream, each with its own
// reference model and expected-result queue.

module tb_adder_sched;

  localparam int NCH = 4;
  localparam int IW  = 8;
  localparam int LEN = 8;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      in_valid;
  logic [NCH*IW-1:0]   in_data;
  logic                out_ready;
  logic [NCH-1:0]      rdy [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Config 0: 16-bit signed, 1: 10-bit signed, 2: 10-bit unsigned.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int AW = (gi == 0) ? 16 : 10;
    localparam bit SG = (gi == 2) ? 1'b0 : 1'b1;
    localparam longint HI = SG ? (longint'(1) <<< (AW-1)) - 1 : (longint'(1) <<< AW) - 1;
    localparam longint LO = SG ? -(longint'(1) <<< (AW-1)) : 0;

    logic          out_valid;
    logic          out_sat;
    logic [AW-1:0] out_data;
    logic [1:0]    out_ch;

    longint        macc [NCH];
    int            mcnt [NCH];
    bit            msat [NCH];
    int            mptr;
    logic [AW+2:0] q [$];

    adder_sched #(
      .N_CH      (NCH),
      .IN_WIDTH  (IW),
      .ACC_WIDTH (AW),
      .ACC_LEN   (LEN),
      .SIGNED    (SG)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (rdy[gi]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_sat   (out_sat)
    );

    always @(negedge clk) begin : model
      logic          ov;
      int            g;
      int            k;
      logic [NCH-1:0] exp_rdy;
      logic [AW+2:0] hd;
      logic [IW-1:0] smp;
      longint        v;
      longint        s;
      bit            hit;
      if (!rst_n) begin
        check($sformatf("c%0d rst in_ready", gi), 32'(rdy[gi]), 0);
        check($sformatf("c%0d rst out_valid", gi), 32'(out_valid), 0);
        check($sformatf("c%0d rst out_data", gi), 32'(out_data), 0);
        check($sformatf("c%0d rst out_ch", gi), 32'(out_ch), 0);
        check($sformatf("c%0d rst out_sat", gi), 32'(out_sat), 0);
        mptr = 0;
        q.delete();
        for (int j = 0; j < NCH; j++) begin
          macc[j] = 0;
          mcnt[j] = 0;
          msat[j] = 0;
        end
      end else begin
        ov = (q.size() != 0);
        check($sformatf("c%0d out_valid", gi), 32'(out_valid), 32'(ov));
        if (ov) begin
          hd = q[0];
          check($sformatf("c%0d out_data", gi), 32'(out_data), 32'(hd[AW-1:0]));
          check($sformatf("c%0d out_ch", gi), 32'(out_ch), 32'(hd[AW+1:AW]));
          check($sformatf("c%0d out_sat", gi), 32'(out_sat), 32'(hd[AW+2]));
        end
        g = -1;
        for (int i = 0; i < NCH; i++) begin
          k = (mptr + i) % NCH;
          if (g < 0 && in_valid[k] && !(mcnt[k] == LEN-1 && ov && !out_ready)) g = k;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check($sformatf("c%0d in_ready", gi), 32'(rdy[gi]), 32'(exp_rdy));
        if (ov && out_ready) void'(q.pop_front());
        if (g >= 0) begin
          smp = in_data[g*IW +: IW];
          if (SG) v = longint'($signed(smp));
          else    v = longint'(smp);
          s   = macc[g] + v;
          hit = 1'b0;
          if (s > HI) begin
            s = HI; hit = 1'b1;
          end else if (s < LO) begin
            s = LO; hit = 1'b1;
          end
          if (mcnt[g] == LEN-1) begin
            q.push_back({msat[g] | hit, 2'(g), s[AW-1:0]});
            macc[g] = 0;
            mcnt[g] = 0;
            msat[g] = 1'b0;
          end else begin
            macc[g] = s;
            mcnt[g] = mcnt[g] + 1;
            msat[g] = msat[g] | hit;
          end
          mptr = (g + 1) % NCH;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [IW-1:0] v);
    bit done;
    done = 1'b0;
    in_valid[ch]         = 1'b1;
    in_data[ch*IW +: IW] = v;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (rdy[0][ch]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
    check($sformatf("send ch%0d accepted", ch), 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;

    for (int v = 1; v <= 8; v++) send(0, IW'(v));
    idle(4);

    in_data  = {NCH{8'd1}};
    in_valid = '1;
    idle(32);
    in_valid = '0;
    idle(4);

    for (int i = 0; i < 8; i++) send(2, 8'h80);
    idle(2);
    for (int i = 0; i < 8; i++) send(2, 8'h01);
    idle(3);

    for (int i = 0; i < 8; i++) send(1, 8'hFF);
    idle(2);
    for (int i = 0; i < 8; i++) send(1, 8'h10);
    idle(3);

    // Stall the output, park ch3 one sample short of closing, let ch1 keep flowing.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 8'h02);
    for (int i = 0; i < 7; i++) send(3, 8'h03);
    in_data[1*IW +: IW] = 8'h05;
    in_data[3*IW +: IW] = 8'h03;
    in_valid = 4'b1010;
    idle(5);
    out_ready = 1'b1;
    idle(1);
    in_valid = '0;
    idle(4);

    // ch1 now sits at count 5; park a pending result and reset over both.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 8'h04);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1, 8'h09);
    idle(4);

    for (int c = 0; c < 400; c++) begin
      in_valid  = NCH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
